// File: rtl/hazard_pkg.sv
// Shared encodings for the mycpu pipeline hazard controller:
// forward-select codes and the divide / data-memory wait FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding comparators for the E-stage ALU operands and
// the D-stage branch compare. M beats W; register 0 never forwards.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d
);

    logic m_live;
    logic w_live;

    assign m_live = regwrite_m && (wreg_m != '0);
    assign w_live = regwrite_w && (wreg_w != '0);

    function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] wm,
                                         input logic [REG_AW-1:0] ww,
                                         input logic              mv,
                                         input logic              wv);
        if (mv && (src == wm))
            return FWD_M;
        else if (wv && (src == ww))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_e = sel_e(rs_e, wreg_m, wreg_w, m_live, w_live);
    assign fwd_b_e = sel_e(rt_e, wreg_m, wreg_w, m_live, w_live);
    assign fwd_a_d = m_live && (rs_d == wreg_m);
    assign fwd_b_d = m_live && (rt_d == wreg_m);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/forward control for the five-stage mycpu core.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] wreg_e,
    input  logic [REG_AW-1:0] wreg_m,
    input  logic [REG_AW-1:0] wreg_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memtoreg_e,
    input  logic              memtoreg_m,
    input  logic              branch_d,
    input  logic              jumpr_d,
    input  logic              div_start_e,
    input  logic              div_ready,
    input  logic              mem_req_m,
    input  logic              mem_data_ok,
    input  logic              except_m,
    input  logic              eret_m,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              div_busy,
    output logic              div_err
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

    div_state_t       div_state, div_next;
    mem_state_t       mem_state, mem_next;
    logic [CNT_W-1:0] div_cnt, div_cnt_inc;
    logic             div_err_set;
    logic             flush_all;
    logic             lwstall, brstall, divstall, memstall;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .rs_e       (rs_e),
        .rt_e       (rt_e),
        .rs_d       (rs_d),
        .rt_d       (rt_d),
        .wreg_m     (wreg_m),
        .wreg_w     (wreg_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .fwd_a_d    (fwd_a_d),
        .fwd_b_d    (fwd_b_d)
    );

    assign flush_all   = except_m || eret_m;
    assign div_cnt_inc = div_cnt + 1'b1;

    assign lwstall  = memtoreg_e && (wreg_e != '0) && ((rs_d == wreg_e) || (rt_d == wreg_e));
    assign brstall  = (branch_d || jumpr_d) &&
                      ((regwrite_e && ((wreg_e == rs_d) || (wreg_e == rt_d))) ||
                       (memtoreg_m && ((wreg_m == rs_d) || (wreg_m == rt_d))));
    assign divstall = ((div_state == DIV_IDLE) && div_start_e) || (div_state == DIV_RUN);
    assign memstall = !mem_data_ok && (((mem_state == MEM_IDLE) && mem_req_m) ||
                                       (mem_state == MEM_WAIT));
    assign div_busy = (div_state != DIV_IDLE);

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_next    = div_state;
        div_err_set = 1'b0;
        unique case (div_state)
            DIV_IDLE: if (div_start_e) div_next = DIV_RUN;
            DIV_RUN: begin
                // A result arriving on the timeout cycle is still accepted.
                if (div_ready) begin
                    div_next = DIV_DONE;
                end else if (div_cnt_inc == CNT_W'(DIV_TIMEOUT)) begin
                    div_next    = DIV_IDLE;
                    div_err_set = 1'b1;
                end
            end
            DIV_DONE: div_next = DIV_IDLE;
            default:  div_next = DIV_IDLE;
        endcase
        if (flush_all) begin
            div_next    = DIV_IDLE;
            div_err_set = 1'b0;
        end
    end

    always_comb begin
        mem_next = mem_state;
        unique case (mem_state)
            MEM_IDLE: if (mem_req_m && !mem_data_ok) mem_next = MEM_WAIT;
            MEM_WAIT: if (mem_data_ok) mem_next = MEM_IDLE;
            default:  mem_next = MEM_IDLE;
        endcase
        if (flush_all) mem_next = MEM_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state <= DIV_IDLE;
            mem_state <= MEM_IDLE;
            div_cnt   <= '0;
            div_err   <= 1'b0;
        end else begin
            div_state <= div_next;
            mem_state <= mem_next;
            div_cnt   <= ((div_state == DIV_RUN) && (div_next == DIV_RUN)) ? div_cnt_inc : '0;
            if (div_err_set) div_err <= 1'b1;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (flush_all) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = lwstall || brstall || divstall || memstall;
            stall_d = stall_f;
            stall_e = divstall || memstall;
            stall_m = memstall;
            // Bubble into E only when E itself advances behind the held D stage.
            flush_e = (lwstall || brstall) && !stall_e;
            flush_w = memstall && !divstall;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_f && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (flush_all && (flush_events != '1)) flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: expected output vectors are
// queued when inputs are driven and popped/compared once outputs settle.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [1:0] fa_e;
        logic [1:0] fb_e;
        logic       fa_d, fb_d;
        logic       sf, sd, se, sm;
        logic       fd, fe, fm, fw;
        logic       busy, err;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       branch_d, jumpr_d, div_start_e, div_ready, mem_req_m, mem_data_ok;
    logic       except_m, eret_m;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m, flush_w, div_busy, div_err;

    out_t obs;
    out_t e;
    sb_t  sb_q[$];
    int   n_tests;
    int   n_fail;
    logic err_exp;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .DIV_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .jumpr_d(jumpr_d),
        .div_start_e(div_start_e), .div_ready(div_ready),
        .mem_req_m(mem_req_m), .mem_data_ok(mem_data_ok),
        .except_m(except_m), .eret_m(eret_m),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .div_busy(div_busy), .div_err(div_err)
    );

    assign obs = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, stall_m,
                  flush_d, flush_e, flush_m, flush_w, div_busy, div_err};

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        wreg_e = '0; wreg_m = '0; wreg_w = '0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0; branch_d = 0; jumpr_d = 0;
        div_start_e = 0; div_ready = 0; mem_req_m = 0; mem_data_ok = 0;
        except_m = 0; eret_m = 0;
    endtask

    function automatic out_t idle_out();
        out_t r = '0;
        r.err = err_exp;
        return r;
    endfunction

    function automatic out_t stall_out(input logic se, input logic sm, input logic fw, input logic busy);
        out_t r = idle_out();
        r.sf = 1'b1; r.sd = 1'b1; r.se = se; r.sm = sm; r.fw = fw; r.busy = busy;
        return r;
    endfunction

    function automatic out_t flush_out(input logic busy);
        out_t r = idle_out();
        r.fd = 1'b1; r.fe = 1'b1; r.fm = 1'b1; r.fw = 1'b1; r.busy = busy;
        return r;
    endfunction

    task automatic check();
        sb_t s;
        s = sb_q.pop_front();
        n_tests++;
        assert (obs === s.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
        end
    endtask

    task automatic expect_out(input string tag, input out_t x);
        sb_q.push_back('{tag: tag, exp: x});
        #1;
        check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0; err_exp = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        expect_out("reset_idle", idle_out());
        rst_n = 1'b1;

        // Forwarding: M beats W, W alone, register 0, D-stage compare
        @(negedge clk); clear_inputs();
        rs_e = 5; wreg_m = 5; wreg_w = 5; regwrite_m = 1; regwrite_w = 1;
        e = idle_out(); e.fa_e = 2'b10; expect_out("fwd_m_prio", e);
        @(negedge clk); regwrite_m = 0; rt_e = 5;
        e = idle_out(); e.fa_e = 2'b01; e.fb_e = 2'b01; expect_out("fwd_w_only", e);
        @(negedge clk); clear_inputs(); regwrite_m = 1; regwrite_w = 1;
        e = idle_out(); expect_out("fwd_reg0", e);
        @(negedge clk); clear_inputs(); rs_d = 3; rt_d = 3; wreg_m = 3; regwrite_m = 1;
        e = idle_out(); e.fa_d = 1; e.fb_d = 1; expect_out("fwd_d_cmp", e);

        // Load-use stall followed by M forwarding
        @(negedge clk); clear_inputs(); memtoreg_e = 1; regwrite_e = 1; wreg_e = 8; rs_d = 8;
        e = stall_out(0, 0, 0, 0); e.fe = 1; expect_out("lw_stall", e);
        @(negedge clk); clear_inputs(); wreg_m = 8; regwrite_m = 1; memtoreg_m = 1; rs_e = 8;
        e = idle_out(); e.fa_e = 2'b10; expect_out("lw_fwd_next", e);
        @(negedge clk); clear_inputs(); memtoreg_e = 1; wreg_e = 0;
        expect_out("lw_reg0", idle_out());

        // Branch/jr stalls
        @(negedge clk); clear_inputs(); jumpr_d = 1; rs_d = 4; regwrite_e = 1; wreg_e = 4;
        e = stall_out(0, 0, 0, 0); e.fe = 1; expect_out("jr_stall_e", e);
        @(negedge clk); clear_inputs(); branch_d = 1; rt_d = 9; memtoreg_m = 1; wreg_m = 9; regwrite_m = 1;
        e = stall_out(0, 0, 0, 0); e.fe = 1; e.fb_d = 1; expect_out("br_stall_m", e);
        @(negedge clk); clear_inputs(); branch_d = 1; rs_d = 4; wreg_e = 4;
        expect_out("br_no_write", idle_out());

        // Load-use during a memory wait: no bubble because E is held
        @(negedge clk); clear_inputs(); memtoreg_e = 1; wreg_e = 8; rs_d = 8; mem_req_m = 1;
        expect_out("lw_under_mem", stall_out(1, 1, 1, 0));
        @(negedge clk); clear_inputs(); mem_req_m = 1; mem_data_ok = 1;
        expect_out("mem_wait_done", idle_out());

        // Divide completing after 33 RUN cycles
        @(negedge clk); clear_inputs(); div_start_e = 1;
        expect_out("div_issue", stall_out(1, 0, 0, 0));
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk); clear_inputs(); div_ready = (c == 33);
            expect_out("div_run", stall_out(1, 0, 0, 1));
        end
        @(negedge clk); clear_inputs();
        e = idle_out(); e.busy = 1; expect_out("div_done", e);
        @(negedge clk); expect_out("div_idle", idle_out());

        // div_ready on the timeout cycle wins
        @(negedge clk); div_start_e = 1;
        expect_out("div2_issue", stall_out(1, 0, 0, 0));
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk); clear_inputs(); div_ready = (c == 64);
            expect_out("div2_run", stall_out(1, 0, 0, 1));
        end
        @(negedge clk); clear_inputs();
        e = idle_out(); e.busy = 1; expect_out("div2_done_noerr", e);

        // Timeout with no div_ready
        @(negedge clk); div_start_e = 1;
        expect_out("div3_issue", stall_out(1, 0, 0, 0));
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk); clear_inputs();
            expect_out("div3_run", stall_out(1, 0, 0, 1));
        end
        @(negedge clk); err_exp = 1'b1;
        expect_out("div_timeout_err", idle_out());

        // Exception in RUN cycle 10
        @(negedge clk); div_start_e = 1;
        expect_out("div4_issue", stall_out(1, 0, 0, 0));
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); clear_inputs();
            expect_out("div4_run", stall_out(1, 0, 0, 1));
        end
        @(negedge clk); except_m = 1;
        expect_out("except_mid_div", flush_out(1));
        @(negedge clk); clear_inputs();
        expect_out("except_div_idle", idle_out());
        @(negedge clk); eret_m = 1;
        expect_out("eret_flush", flush_out(0));

        // Memory wait of 3 cycles, then same-cycle completion
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clear_inputs(); mem_req_m = 1;
            expect_out("mem_wait", stall_out(1, 1, 1, 0));
        end
        @(negedge clk); mem_data_ok = 1;
        expect_out("mem_ok", idle_out());
        @(negedge clk); clear_inputs();
        expect_out("mem_idle", idle_out());
        @(negedge clk); mem_req_m = 1; mem_data_ok = 1;
        expect_out("mem_same_cycle", idle_out());
        @(negedge clk); clear_inputs();
        expect_out("mem_same_idle", idle_out());

        // Exception beats memstall
        @(negedge clk); mem_req_m = 1;
        expect_out("mem_x_wait", stall_out(1, 1, 1, 0));
        @(negedge clk); except_m = 1;
        expect_out("except_mem", flush_out(0));
        @(negedge clk); clear_inputs();
        expect_out("except_mem_idle", idle_out());

        // Divide and memory together: no W flush while divstall
        @(negedge clk); mem_req_m = 1; div_start_e = 1;
        expect_out("div_and_mem", stall_out(1, 1, 0, 0));
        @(negedge clk); clear_inputs(); except_m = 1;
        expect_out("div_mem_flush", flush_out(1));
        @(negedge clk); clear_inputs();
        expect_out("div_mem_idle", idle_out());

        // Async reset mid-WAIT with no clock edge
        @(negedge clk); mem_req_m = 1;
        expect_out("rst_pre_wait", stall_out(1, 1, 1, 0));
        @(negedge clk); clear_inputs();
        expect_out("wait_hold", stall_out(1, 1, 1, 0));
        #1; rst_n = 1'b0; err_exp = 1'b0;
        expect_out("async_rst", idle_out());
        @(negedge clk); rst_n = 1'b1;
        expect_out("rst_release", idle_out());
        @(negedge clk);
        expect_out("rst_fsm_idle", idle_out());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the five-stage mycpu core.
- Drives the stall enables and flush/clear inputs of every inter-stage pipeline register (F/D, D/E, E/M, M/W).
- Resolves data hazards by forwarding or stalling.
- Sequences multi-cycle divide and data-memory waits with small FSMs.
- Flushes the pipe on exceptions and eret.

Parameters:
- REG_AW, 5, register-number width.
- DIV_TIMEOUT, 64, maximum cycles in DIV_RUN before div_err is raised.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_d, rt_d  in  REG_AW  D-stage source registers.
- rs_e, rt_e  in  REG_AW  E-stage source registers.
- wreg_e, wreg_m, wreg_w  in  REG_AW  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  destination write enables.
- memtoreg_e, memtoreg_m  in  1  load in E / M.
- branch_d  in  1  D-stage branch needs operands.
- jumpr_d  in  1  D-stage jr/jalr needs operands.
- div_start_e  in  1  divide issued in E.
- div_ready  in  1  divider result valid (one-cycle pulse).
- mem_req_m  in  1  M-stage data access.
- mem_data_ok  in  1  data bus completion.
- except_m  in  1  exception taken in M.
- eret_m  in  1  eret in M.
- fwd_a_e, fwd_b_e  out  2  E operand select: 00 regfile, 01 W result, 10 M result.
- fwd_a_d, fwd_b_d  out  1  D compare operand from M.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e, flush_m, flush_w  out  1  clear the stage register to 0.
- div_busy  out  1  divide FSM not IDLE.
- div_err  out  1  sticky timeout flag.

Behaviour:
- Reset: div FSM and mem FSM in IDLE, timeout counter 0, div_err 0. All outputs are 0 during and after reset until inputs assert. Reset mid-divide or mid-access abandons the operation; no flush pulse is emitted.
- Forwarding (combinational). Register 0 never forwards. M has priority over W.
  - fwd_a_e = 10 if rs_e == wreg_m and regwrite_m; else 01 if rs_e == wreg_w and regwrite_w; else 00. fwd_b_e is the same using rt_e.
  - fwd_a_d = 1 if rs_d == wreg_m and regwrite_m. fwd_b_d is the same using rt_d.
- lwstall = memtoreg_e and (rs_d == wreg_e or rt_d == wreg_e), with wreg_e != 0.
- brstall = (branch_d or jumpr_d) and one of:
  - (regwrite_e and wreg_e in {rs_d, rt_d});
  - (memtoreg_m and wreg_m in {rs_d, rt_d}).
- Divide FSM:
  - IDLE -> RUN on div_start_e.
  - RUN -> DONE on div_ready.
  - DONE -> IDLE unconditionally after 1 cycle.
  - In RUN the timeout counter increments each cycle. On reaching DIV_TIMEOUT: div_err <= 1, FSM -> IDLE.
  - divstall = (state == IDLE and div_start_e) or state == RUN.
- Mem FSM:
  - IDLE -> WAIT when mem_req_m and not mem_data_ok.
  - WAIT -> IDLE on mem_data_ok.
  - memstall = (IDLE and mem_req_m and not mem_data_ok) or (WAIT and not mem_data_ok).
  - A same-cycle mem_data_ok completes with zero stall.
- Stall outputs:
  - stall_f = stall_d = lwstall or brstall or divstall or memstall.
  - stall_e = divstall or memstall.
  - stall_m = memstall.
- Flush outputs:
  - flush_e = (lwstall or brstall) and not stall_e. This inserts a bubble behind the held D stage.
  - flush_w = memstall and not divstall.
  - except_m or eret_m:
    - flush_d, flush_e, flush_m, flush_w all 1, and all stall outputs forced to 0.
    - The div FSM returns to IDLE and the mem FSM returns to IDLE next edge.
    - A pending divide result is discarded.
    - This overrides every other condition.
- Simultaneous events:
  - except_m with memstall: the flush wins.
  - div_ready in the same cycle as a timeout: div_ready wins (no error).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (32-bit) and flush_events (32-bit).
  - stall_cycles increments on every cycle with stall_f = 1.
  - flush_events increments on every cycle with except_m or eret_m.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - forward-select constants FWD_RF = 00, FWD_W = 01, FWD_M = 10;
  - div FSM encodings DIV_IDLE, DIV_RUN, DIV_DONE;
  - mem FSM encodings MEM_IDLE, MEM_WAIT.
- One sub-module, hazard_fwd_unit: the purely combinational forwarding comparators, instantiated once.
- FSMs, stall logic and flush logic stay in hazard_ctrl.

Test Plan:
- Load-use: memtoreg_e = 1, wreg_e = 8, rs_d = 8 -> stall_f = stall_d = 1 and flush_e = 1 for 1 cycle; fwd_a_e = 10 next cycle.
- Forward priority: wreg_m = wreg_w = 5, both regwrite, rs_e = 5 -> fwd_a_e = 10. With rs_e = 0 -> fwd_a_e = 00.
- Divide: div_start_e, then div_ready after 33 cycles -> stall_e = 1 for 34 cycles, div_busy through DONE, div_err = 0. With no div_ready -> div_err = 1 after 64 cycles.
- Memory wait: mem_req_m with mem_data_ok held 0 for 3 cycles -> stall_m = 1 and flush_w = 1 for 3 cycles. Same-cycle data_ok -> no stall.
- Exception mid-divide: except_m in cycle 10 of RUN -> all flush outputs 1, all stall outputs 0 that cycle, div_busy = 0 next cycle.
- Async reset: rst_n low mid-WAIT without a clock edge -> stall_m = 0 immediately; the FSM is IDLE after release.
